// File: rtl/conv_window_gen_if.sv
// Stream bundle for conv_window_gen: raster pixel input and window output,
// each with its own valid/ready handshake, plus the end-of-frame marker.
interface conv_window_gen_if #(
    parameter int SIZE      = 3,
    parameter int WIDTH_BIT = 8
) ();

    logic [WIDTH_BIT-1:0]                     pix_in;
    logic                                     pix_valid;
    logic                                     pix_ready;
    logic [SIZE-1:0][SIZE-1:0][WIDTH_BIT-1:0] winMatrixO;
    logic                                     win_valid;
    logic                                     win_ready;
    logic                                     frame_done;

    // Source/sink side: drives pixels in, takes windows out.
    modport master (
        output pix_in,
        output pix_valid,
        output win_ready,
        input  pix_ready,
        input  winMatrixO,
        input  win_valid,
        input  frame_done
    );

    // Window generator side.
    modport slave (
        input  pix_in,
        input  pix_valid,
        input  win_ready,
        output pix_ready,
        output winMatrixO,
        output win_valid,
        output frame_done
    );

endinterface

// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator. Takes a raster-order pixel stream, keeps the
// two previous lines in line buffers and emits every fully populated window
// (no padding) one cycle after the pixel that completes it.
module conv_window_gen #(
    parameter int SIZE      = 3,
    parameter int WIDTH_BIT = 8,
    parameter int IMG_W     = 8,
    parameter int IMG_H     = 8
) (
    input  logic             clock,
    input  logic             reset,
    conv_window_gen_if.slave bus
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_PRIME = RW'(1);
    localparam logic [CW-1:0] COL_WIN   = CW'(2);

    // Only the 3x3 geometry is implemented; reject anything else at elaboration.
    if (SIZE != 3) begin : g_size_check
        $error("conv_window_gen: only SIZE=3 is supported");
    end
    if ((IMG_W < SIZE) || (IMG_H < SIZE)) begin : g_frame_check
        $error("conv_window_gen: IMG_W and IMG_H must be >= SIZE");
    end

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                                   state_r;
    state_t                                   state_nxt_s;
    logic [CW-1:0]                            col_r;
    logic [RW-1:0]                            row_r;
    logic [WIDTH_BIT-1:0]                     lb0_r [IMG_W];
    logic [WIDTH_BIT-1:0]                     lb1_r [IMG_W];
    logic [SIZE-1:0][SIZE-1:0][WIDTH_BIT-1:0] win_r;
    logic                                     win_valid_r;
    logic                                     frame_done_r;

    logic                                     pix_ready_s;
    logic                                     accept_s;
    logic                                     col_last_s;
    logic                                     row_last_s;
    logic                                     qualify_s;
    logic                                     frame_end_s;
    logic [WIDTH_BIT-1:0]                     top_s;
    logic [WIDTH_BIT-1:0]                     mid_s;

    // Handshake decode and line-buffer read for the current column.
    always_comb begin
        pix_ready_s = !win_valid_r || bus.win_ready;
        accept_s    = bus.pix_valid && pix_ready_s;
        col_last_s  = (col_r == COL_LAST);
        row_last_s  = (row_r == ROW_LAST);
        frame_end_s = accept_s && col_last_s && row_last_s;
        // A window only completes once two full lines are buffered and the
        // shift window holds three columns of the current row.
        qualify_s   = accept_s && (state_r == ST_RUN) && (col_r >= COL_WIN);
        top_s       = lb1_r[col_r];
        mid_s       = lb0_r[col_r];
    end

    // Fill/run sequencing: FILL until rows 0 and 1 are buffered, RUN to frame end.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_FILL: begin
                if (accept_s && col_last_s && (row_r == ROW_PRIME)) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_FILL;
                end
            end
            ST_RUN: begin
                if (frame_end_s) begin
                    state_nxt_s = ST_FILL;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s = ST_FILL;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_FILL;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Raster position of the next pixel to be accepted.
    always_ff @(posedge clock) begin
        if (reset) begin
            col_r <= {CW{1'b0}};
            row_r <= {RW{1'b0}};
        end else if (accept_s) begin
            if (col_last_s) begin
                col_r <= {CW{1'b0}};
                if (row_last_s) begin
                    row_r <= {RW{1'b0}};
                end else begin
                    row_r <= row_r + RW'(1);
                end
            end else begin
                col_r <= col_r + CW'(1);
            end
        end
    end

    // Line buffers: lb0 is one line up, lb1 two lines up. Not reset; the FILL
    // phase overwrites every entry before it can reach a window.
    always_ff @(posedge clock) begin
        if (accept_s) begin
            lb1_r[col_r] <= lb0_r[col_r];
            lb0_r[col_r] <= bus.pix_in;
        end
    end

    // Shift window: every accepted pixel shifts columns left and appends the
    // new column, so columns 0/1 of each row prime the window without emitting.
    always_ff @(posedge clock) begin
        if (reset) begin
            win_r <= {(SIZE * SIZE * WIDTH_BIT){1'b0}};
        end else if (accept_s) begin
            for (int r = 0; r < SIZE; r++) begin
                win_r[r][0] <= win_r[r][1];
                win_r[r][1] <= win_r[r][2];
            end
            win_r[0][2] <= top_s;
            win_r[1][2] <= mid_s;
            win_r[2][2] <= bus.pix_in;
        end
    end

    // Output valid and end-of-frame flag; a qualifying accept wins over a
    // same-cycle consumption so windows can stream back to back.
    always_ff @(posedge clock) begin
        if (reset) begin
            win_valid_r  <= 1'b0;
            frame_done_r <= 1'b0;
        end else if (qualify_s) begin
            win_valid_r  <= 1'b1;
            frame_done_r <= frame_end_s;
        end else if (win_valid_r && bus.win_ready) begin
            win_valid_r  <= 1'b0;
            frame_done_r <= 1'b0;
        end
    end

    assign bus.pix_ready  = pix_ready_s;
    assign bus.winMatrixO = win_r;
    assign bus.win_valid  = win_valid_r;
    assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_conv_window_gen.sv
// Randomised testbench for conv_window_gen with a frame-array reference model.
module tb_conv_window_gen;

    localparam int SIZE = 3;
    localparam int WB   = 8;
    localparam int W    = 8;
    localparam int H    = 8;

    typedef logic [SIZE-1:0][SIZE-1:0][WB-1:0] win_t;
    typedef struct packed {
        win_t win;
        logic last;
    } exp_t;

    logic clock_s;
    logic reset_s;

    conv_window_gen_if #(.SIZE(SIZE), .WIDTH_BIT(WB)) bif ();

    conv_window_gen #(
        .SIZE(SIZE), .WIDTH_BIT(WB), .IMG_W(W), .IMG_H(H)
    ) dut (
        .clock (clock_s),
        .reset (reset_s),
        .bus   (bif)
    );

    initial clock_s = 1'b0;
    always #5 clock_s = ~clock_s;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: the frame as written so far and the position of
    // the next pixel; windows are cut straight out of the frame array.
    logic [WB-1:0] img [0:H-1][0:W-1];
    int   mrow = 0;
    int   mcol = 0;
    int   pframes = 0;
    int   acc_total = 0;
    exp_t exp_q[$];
    win_t win_log[$];
    int   fd_idx[$];
    int   win_cnt = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic win_t pat_win(input int tl);
        win_t w;
        for (int r = 0; r < SIZE; r++)
            for (int c = 0; c < SIZE; c++)
                w[r][c] = 8'(tl + r * W + c);
        return w;
    endfunction

    function automatic win_t log_at(input int i);
        if (i < win_log.size()) return win_log[i];
        else return '0;
    endfunction

    task automatic model_accept(input logic [WB-1:0] pin);
        exp_t e;
        img[mrow][mcol] = pin;
        acc_total++;
        if (mrow >= 2 && mcol >= 2) begin
            for (int r = 0; r < SIZE; r++)
                for (int c = 0; c < SIZE; c++)
                    e.win[r][c] = img[mrow - 2 + r][mcol - 2 + c];
            e.last = (mrow == H - 1) && (mcol == W - 1);
            exp_q.push_back(e);
        end
        if (mcol == W - 1) begin
            mcol = 0;
            if (mrow == H - 1) begin
                mrow = 0;
                pframes++;
            end else begin
                mrow++;
            end
        end else begin
            mcol++;
        end
    endtask

    // One clock: drive at negedge, observe 1 ns later (what the next posedge sees).
    task automatic step(input logic pv, input logic [WB-1:0] pin, input logic wr);
        logic exp_valid;
        @(negedge clock_s);
        bif.pix_valid = pv;
        bif.pix_in    = pin;
        bif.win_ready = wr;
        #1;
        exp_valid = (exp_q.size() != 0);
        chk("win_valid", bif.win_valid, exp_valid);
        chk("pix_ready", bif.pix_ready, !exp_valid || wr);
        if (exp_valid) begin
            chk("window", bif.winMatrixO, exp_q[0].win);
            chk("frame_done", bif.frame_done, exp_q[0].last);
            if (wr) begin
                if (exp_q[0].last) fd_idx.push_back(win_cnt);
                win_log.push_back(bif.winMatrixO);
                win_cnt++;
                void'(exp_q.pop_front());
            end
        end else begin
            chk("frame_done_idle", bif.frame_done, 1'b0);
        end
        if (pv && (!exp_valid || wr)) model_accept(pin);
    endtask

    task automatic do_reset();
        @(negedge clock_s);
        reset_s = 1'b1;
        bif.pix_valid = 1'b0;
        bif.win_ready = 1'b0;
        @(negedge clock_s);
        reset_s = 1'b0;
        exp_q.delete();
        mrow = 0;
        mcol = 0;
        #1;
        chk("rst_win_valid", bif.win_valid, 1'b0);
        chk("rst_frame_done", bif.frame_done, 1'b0);
        chk("rst_window", bif.winMatrixO, '0);
        chk("rst_pix_ready", bif.pix_ready, 1'b1);
    endtask

    // mode 0: continuous pattern; 1: random gaps/ready/data; 2: stall first window 3 cycles.
    task automatic run_frame(input int npix, input int mode, input int base, input bit drain);
        int start = acc_total;
        int budget = 0;
        int stalls = 0;
        logic pv, wr;
        logic [WB-1:0] pin;
        pframes = 0;
        win_cnt = 0;
        win_log.delete();
        fd_idx.delete();
        while ((acc_total - start) < npix && budget < 5000) begin
            pin = 8'(base + pframes * W * H + mrow * W + mcol);
            pv = 1'b1;
            wr = 1'b1;
            if (mode == 1) begin
                pin = 8'($urandom);
                pv  = 1'($urandom_range(0, 1));
                wr  = 1'($urandom_range(0, 1));
            end else if (mode == 2 && exp_q.size() != 0 && stalls < 3) begin
                wr = 1'b0;
                stalls++;
            end
            step(pv, pin, wr);
            budget++;
        end
        if (budget >= 5000) chk("stream_timeout", 1'b1, 1'b0);
        if (drain) begin
            budget = 0;
            while (exp_q.size() != 0 && budget < 50) begin
                step(1'b0, 8'd0, 1'b1);
                budget++;
            end
            chk("drain_empty", exp_q.size(), 0);
        end
    endtask

    initial begin
        reset_s = 1'b1;
        bif.pix_valid = 1'b0;
        bif.pix_in = 8'd0;
        bif.win_ready = 1'b0;
        repeat (2) @(negedge clock_s);
        do_reset();

        // Basic frame with row wrap and frame end.
        run_frame(W * H, 0, 0, 1'b1);
        chk("basic_count", win_cnt, 36);
        chk("basic_fd_count", fd_idx.size(), 1);
        chk("basic_first", log_at(0), pat_win(0));
        chk("basic_rowwrap", log_at(6), pat_win(8));
        chk("basic_last", log_at(35), pat_win(45));
        chk("basic_fd_pos", (fd_idx.size() > 0) ? fd_idx[0] : -1, 35);

        // Backpressure on the first window.
        run_frame(W * H, 2, 0, 1'b1);
        chk("bp_count", win_cnt, 36);
        chk("bp_first", log_at(0), pat_win(0));
        chk("bp_last", log_at(35), pat_win(45));

        // Bursty random stream.
        for (int k = 0; k < 3; k++) begin
            run_frame(W * H, 1, 0, 1'b1);
            chk("burst_count", win_cnt, 36);
            chk("burst_fd_count", fd_idx.size(), 1);
        end

        // Mid-frame reset, then a fresh frame.
        run_frame(20, 0, 0, 1'b0);
        do_reset();
        run_frame(W * H, 0, 100, 1'b1);
        chk("mrst_count", win_cnt, 36);
        chk("mrst_first", log_at(0), pat_win(100));

        // Two frames back to back.
        run_frame(2 * W * H, 0, 0, 1'b1);
        chk("b2b_count", win_cnt, 72);
        chk("b2b_fd_count", fd_idx.size(), 2);
        chk("b2b_fd_gap", (fd_idx.size() > 1) ? (fd_idx[1] - fd_idx[0]) : -1, 36);
        chk("b2b_f2_first", log_at(36), pat_win(64));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Streaming producer of the SIZE x SIZE pixel windows consumed by the conv MAC.
- Accepts a raster-order pixel stream (row-major, one pixel per handshake) for an IMG_W x IMG_H frame.
- Buffers SIZE-1 previous lines and emits every fully-populated window ("valid" convolution, no padding) with a valid/ready handshake.
- Sits between the image source and the conv inpMatrixI input.

Parameters:
SIZE, 3, window edge; only 3 supported (elaborate-time check).
WIDTH_BIT, 8, pixel width in bits.
IMG_W, 8, frame width in pixels; must be >= SIZE.
IMG_H, 8, frame height in pixels; must be >= SIZE.

Ports:
clock  input  1  rising-edge clock.
reset  input  1  synchronous, active-high reset.
pix_in  input  WIDTH_BIT  incoming pixel.
pix_valid  input  1  pix_in is valid.
pix_ready  output  1  block accepts pix_in this cycle.
winMatrixO  output  [WIDTH_BIT-1:0] x [SIZE-1:0][SIZE-1:0]  current window; [r][c], r=0 oldest row, c=0 leftmost column.
win_valid  output  1  winMatrixO holds a new window.
win_ready  input  1  consumer takes the window this cycle.
frame_done  output  1  one-cycle pulse coincident with the last window of a frame.

Behaviour:
- Accept: pixel accepted when pix_valid && pix_ready.
- pix_ready = !win_valid || win_ready (combinational). No pixel is accepted while an unconsumed window is held.
- Counters col (0..IMG_W-1) and row (0..IMG_H-1) address the accepted pixel.
  - On accept: col++. At col==IMG_W-1, col->0 and row++. At row==IMG_H-1, row->0 (frame wrap).
- Line buffers: two IMG_W-deep buffers indexed by col.
  - On accept: lb1[col] <= lb0[col]; lb0[col] <= pix_in.
  - lb1 holds the row two lines up; lb0 holds the row one line up.
- Shift window: on each accept, columns shift left (c=1->0, c=2->1). New column c=2 is {lb1[col], lb0[col], pix_in} for rows 0, 1, 2.
- Window emission:
  - win_valid is set on the cycle after an accept where row>=2 and col>=2.
  - win_valid is cleared on win_valid && win_ready with no new qualifying accept.
  - A qualifying accept in the same cycle as consumption keeps win_valid=1 and loads the next window (back-to-back, one window per cycle).
- Latency: 1 cycle from the accepting pixel edge to win_valid/winMatrixO.
- States:
  - FILL: row<2. No windows emitted.
  - RUN: row>=2. Windows emitted for col>=2.
  - FILL->RUN on accept of the last pixel of row 1.
  - RUN->FILL on accept of pixel (IMG_H-1, IMG_W-1).
- Row boundary: no window spans rows. Pixels at col 0,1 of any row only prime the shift window.
- Stall: while win_valid && !win_ready, winMatrixO, win_valid, counters and buffers hold unchanged.
- frame_done: asserted with win_valid for the window produced by pixel (IMG_H-1, IMG_W-1). Held with it under stall. Deasserted when that window is consumed.
- Windows per frame: (IMG_W-2)*(IMG_H-2).
- Reset, including mid-frame:
  - col=0, row=0, state=FILL; win_valid=0, frame_done=0, winMatrixO=0.
  - pix_ready=1 in the cycle after reset deasserts.
  - Line-buffer contents are not reset; the FILL gating makes stale data unobservable.
- pix_valid low: no state change; a held window remains held.
- Arithmetic: counters sized by $clog2 of IMG_W/IMG_H. No pixel arithmetic; pixel data passes through unmodified.

Test Plan:
- Basic frame: 8x8 frame, pixel = row*8+col, win_ready=1.
  - First win_valid one cycle after pixel 18, with rows {0,1,2},{8,9,10},{16,17,18}.
  - 36 windows total.
  - Last window {45,46,47},{53,54,55},{61,62,63} with frame_done=1.
- Row wrap: after window ending at pixel 23 (row 2, col 7), no window is produced for pixels 24 and 25. Next window is {8,9,10},{16,17,18},{24,25,26}.
- Backpressure: hold win_ready=0 for 3 cycles on the first window.
  - pix_ready=0 throughout; window {0,1,2},{8,9,10},{16,17,18} stays stable.
  - After release, all 36 windows arrive in order with no loss or duplication.
- Bursty input: random pix_valid gaps (about 50% duty) plus random win_ready. Windows are bit-identical to a golden model; count is 36.
- Mid-frame reset: assert reset for 1 cycle after 20 pixels accepted, then stream a fresh frame with pixel = 100+row*8+col.
  - No window before pixel 18 of the new frame.
  - First window is {100,101,102},{108,109,110},{116,117,118}.
- Back-to-back frames: two 8x8 frames with no gap.
  - frame_done pulses exactly twice, 36 windows apart.
  - First window of frame 2 contains only frame-2 pixels.
